// File: rtl/pdn_pkg.sv
// Shared constants and types for the PuDianNao cold-buffer write path.
package pdn_pkg;

    localparam int unsigned DATA_W        = 32;
    localparam int unsigned ROW_WORDS     = 256;
    localparam int unsigned BEAT_WORDS    = 8;
    localparam int unsigned DEPTH         = 32;
    localparam int unsigned IDX_W         = 5;
    localparam int unsigned BEATS_PER_ROW = ROW_WORDS / BEAT_WORDS;
    localparam int unsigned BEAT_CNT_W    = $clog2(BEATS_PER_ROW);
    localparam int unsigned ROWS_W        = IDX_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } load_state_e;

    // Requests larger than the buffer are limited to one full pass over it.
    function automatic logic [ROWS_W-1:0] clamp_rows(input logic [ROWS_W-1:0] n);
        return (n > ROWS_W'(DEPTH)) ? ROWS_W'(DEPTH) : n;
    endfunction

endpackage

// File: rtl/cold_row_assembler.sv
// Collects BEAT_WORDS-wide input beats into one ROW_WORDS-wide cold-buffer row.
module cold_row_assembler
    import pdn_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              beat_en,
    input  logic [DATA_W-1:0] beat [BEAT_WORDS],
    output logic [DATA_W-1:0] row [ROW_WORDS],
    output logic              last_beat_c
);

    logic [BEAT_CNT_W-1:0] beat_cnt_q;
    logic [BEAT_CNT_W-1:0] beat_cnt_d;
    logic [DATA_W-1:0]     row_q [BEATS_PER_ROW][BEAT_WORDS];

    assign last_beat_c = (beat_cnt_q == BEAT_CNT_W'(BEATS_PER_ROW - 1));

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (clear) begin
            beat_cnt_d = '0;
        end else if (beat_en) begin
            beat_cnt_d = last_beat_c ? '0 : beat_cnt_q + BEAT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q <= '0;
            for (int b = 0; b < int'(BEATS_PER_ROW); b++) begin
                for (int j = 0; j < int'(BEAT_WORDS); j++) begin
                    row_q[b][j] <= '0;
                end
            end
        end else begin
            beat_cnt_q <= beat_cnt_d;
            if (beat_en && !clear) begin
                for (int j = 0; j < int'(BEAT_WORDS); j++) begin
                    row_q[beat_cnt_q][j] <= beat[j];
                end
            end
        end
    end

    // Beat-major storage presented as a flat row of words.
    always_comb begin
        for (int b = 0; b < int'(BEATS_PER_ROW); b++) begin
            for (int j = 0; j < int'(BEAT_WORDS); j++) begin
                row[b * int'(BEAT_WORDS) + j] = row_q[b][j];
            end
        end
    end

endmodule

// File: rtl/cold_buffer_loader.sv
// Writer-side front end of the cold buffer: assembles input beats into rows and
// writes them to consecutive (wrapping) row indices starting at a programmed base.
module cold_buffer_loader
    import pdn_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [IDX_W-1:0]  base_idx,
    input  logic [IDX_W:0]    num_rows,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data [BEAT_WORDS],
    output logic              s_ready,
    output logic [DATA_W-1:0] buf_data [ROW_WORDS],
    output logic [IDX_W-1:0]  buf_idx,
    output logic              buf_write_en,
    output logic              busy,
    output logic              done
);

    load_state_e state_q;
    load_state_e state_d;

    logic [IDX_W-1:0]  base_q;
    logic [IDX_W-1:0]  base_d;
    logic [ROWS_W-1:0] num_q;
    logic [ROWS_W-1:0] num_d;
    logic [ROWS_W-1:0] row_q;
    logic [ROWS_W-1:0] row_d;

    logic [ROWS_W-1:0] num_clamped;
    logic              start_acc;
    logic              beat_en;
    logic              last_beat_c;
    logic              last_row;

    assign num_clamped = clamp_rows(num_rows);
    assign start_acc   = (state_q == ST_IDLE) && start;
    assign beat_en     = (state_q == ST_FILL) && s_valid;
    assign last_row    = (row_q == num_q - ROWS_W'(1));

    cold_row_assembler u_asm (
        .clk         (clk),
        .rst         (rst),
        .clear       (start_acc),
        .beat_en     (beat_en),
        .beat        (s_data),
        .row         (buf_data),
        .last_beat_c (last_beat_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (num_clamped == '0) ? ST_DONE : ST_FILL;
                end
            end
            ST_FILL: begin
                if (s_valid && last_beat_c) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                state_d = last_row ? ST_DONE : ST_FILL;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake and status outputs decode the current state only.
    always_comb begin
        s_ready      = 1'b0;
        buf_write_en = 1'b0;
        done         = 1'b0;
        busy         = (state_q != ST_IDLE);
        unique case (state_q)
            ST_FILL:  s_ready      = 1'b1;
            ST_WRITE: buf_write_en = 1'b1;
            ST_DONE:  done         = 1'b1;
            default:  ;
        endcase
    end

    // Load parameters are captured only when a start is accepted.
    always_comb begin
        base_d = base_q;
        num_d  = num_q;
        row_d  = row_q;
        if (start_acc) begin
            base_d = base_idx;
            num_d  = num_clamped;
            row_d  = '0;
        end else if ((state_q == ST_WRITE) && !last_row) begin
            row_d = row_q + ROWS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q <= '0;
            num_q  <= '0;
            row_q  <= '0;
        end else begin
            base_q <= base_d;
            num_q  <= num_d;
            row_q  <= row_d;
        end
    end

    // IDX_W-bit sum wraps modulo DEPTH.
    assign buf_idx = base_q + IDX_W'(row_q);

endmodule

// File: tb/tb_cold_buffer_loader.sv
// Directed, table-driven bench for cold_buffer_loader with a write/done monitor.
`timescale 1ns/1ps
module tb_cold_buffer_loader;
    import pdn_pkg::*;

    localparam int unsigned ROW_BITS = DATA_W * ROW_WORDS;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [IDX_W-1:0]  base_idx;
    logic [IDX_W:0]    num_rows;
    logic              s_valid;
    logic [DATA_W-1:0] s_data [BEAT_WORDS];
    logic              s_ready;
    logic [DATA_W-1:0] buf_data [ROW_WORDS];
    logic [IDX_W-1:0]  buf_idx;
    logic              buf_write_en;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    cold_buffer_loader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_idx     (base_idx),
        .num_rows     (num_rows),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .buf_data     (buf_data),
        .buf_idx      (buf_idx),
        .buf_write_en (buf_write_en),
        .busy         (busy),
        .done         (done)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records every write and done pulse, sampled mid-cycle.
    int                  wr_idx_q[$];
    logic [ROW_BITS-1:0] wr_row_q[$];
    int                  done_cyc_q[$];
    int                  ready_in_write = 0;
    logic [ROW_BITS-1:0] snap;

    always @(negedge clk) begin
        if (buf_write_en) begin
            for (int i = 0; i < int'(ROW_WORDS); i++) snap[i*DATA_W +: DATA_W] = buf_data[i];
            wr_idx_q.push_back(int'(buf_idx));
            wr_row_q.push_back(snap);
            if (s_ready) ready_in_write++;
        end
        if (done) done_cyc_q.push_back(cyc);
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input int base, input int num, output int sc);
        start    = 1'b1;
        base_idx = IDX_W'(base);
        num_rows = (IDX_W+1)'(num);
        sc       = cyc;
        tick();
        start    = 1'b0;
    endtask

    // Offers beats until nbeats have been accepted; word j of global beat g is tag+g*8+j.
    task automatic feed(input int nbeats, input int stall, input logic [31:0] tag, inout int g);
        int got = 0;
        int budget = nbeats * 8 + 64;
        while (got < nbeats && budget > 0) begin
            logic acc;
            s_valid = ($urandom_range(99) >= stall);
            for (int j = 0; j < int'(BEAT_WORDS); j++) s_data[j] = tag + DATA_W'(g * 8 + j);
            acc = s_valid && s_ready;
            tick();
            if (acc) begin
                g++;
                got++;
            end
            budget--;
        end
        s_valid = 1'b0;
        if (got != nbeats) chk("feed_budget", got, nbeats);
    endtask

    task automatic wait_done(input int sd);
        int budget = 2000;
        while (done_cyc_q.size() <= sd && budget > 0) begin
            tick();
            budget--;
        end
        tick();
        tick();
    endtask

    // Compares the written rows from index sw on against the expected pattern.
    task automatic check_rows(input int sw, input int n, input int base, input logic [31:0] tag);
        for (int k = 0; k < n && (sw + k) < wr_idx_q.size(); k++) begin
            logic [ROW_BITS-1:0] r = wr_row_q[sw + k];
            int nbad = 0;
            int first = -1;
            logic [31:0] fa = '0;
            logic [31:0] fe = '0;
            chk($sformatf("wr%0d_idx", k), wr_idx_q[sw + k], (base + k) % int'(DEPTH));
            for (int i = 0; i < int'(ROW_WORDS); i++) begin
                logic [31:0] e = tag + 32'(k * 256 + i);
                if (r[i*DATA_W +: DATA_W] != e) begin
                    if (first < 0) begin
                        first = i;
                        fa = r[i*DATA_W +: DATA_W];
                        fe = e;
                    end
                    nbad++;
                end
            end
            checks++;
            if (nbad != 0) begin
                errors++;
                $display("FAIL wr%0d_data: %0d words wrong, word %0d got %h expected %h",
                         k, nbad, first, fa, fe);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        int nz = 0;
        for (int i = 0; i < int'(ROW_WORDS); i++) if (buf_data[i] != '0) nz++;
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_buf_write_en"}, buf_write_en, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_buf_idx"}, buf_idx, 0);
        chk({tag, "_buf_data_nonzero_words"}, nz, 0);
    endtask

    typedef struct {
        int          base;
        int          num;
        int          stall;
        logic [31:0] tag;
        int          exp_wr;
        int          exp_lat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int sw, sd, srw, sc, g;
        bit [31:0] seen;

        vecs[0] = '{base: 0,  num: 1,  stall: 0,  tag: 32'h0,       exp_wr: 1,  exp_lat: 34};
        vecs[1] = '{base: 30, num: 4,  stall: 0,  tag: 32'h0001_0000, exp_wr: 4,  exp_lat: 133};
        vecs[2] = '{base: 5,  num: 2,  stall: 0,  tag: 32'h0002_0000, exp_wr: 2,  exp_lat: 67};
        vecs[3] = '{base: 5,  num: 2,  stall: 50, tag: 32'h0002_0000, exp_wr: 2,  exp_lat: -1};
        vecs[4] = '{base: 7,  num: 0,  stall: 0,  tag: 32'h0003_0000, exp_wr: 0,  exp_lat: 1};
        vecs[5] = '{base: 3,  num: 40, stall: 0,  tag: 32'h0004_0000, exp_wr: 32, exp_lat: 1057};

        rst = 1'b1;
        start = 1'b0;
        s_valid = 1'b0;
        base_idx = '0;
        num_rows = '0;
        for (int j = 0; j < int'(BEAT_WORDS); j++) s_data[j] = '0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        for (int v = 0; v < 6; v++) begin
            sw = wr_idx_q.size();
            sd = done_cyc_q.size();
            srw = ready_in_write;
            g = 0;
            start_load(vecs[v].base, vecs[v].num, sc);
            feed(vecs[v].exp_wr * int'(BEATS_PER_ROW), vecs[v].stall, vecs[v].tag, g);
            wait_done(sd);
            chk($sformatf("v%0d_writes", v), wr_idx_q.size() - sw, vecs[v].exp_wr);
            check_rows(sw, vecs[v].exp_wr, vecs[v].base, vecs[v].tag);
            chk($sformatf("v%0d_done_pulses", v), done_cyc_q.size() - sd, 1);
            if (vecs[v].exp_lat >= 0 && done_cyc_q.size() > sd)
                chk($sformatf("v%0d_done_latency", v), done_cyc_q[sd] - sc, vecs[v].exp_lat);
            chk($sformatf("v%0d_ready_in_write", v), ready_in_write - srw, 0);
            chk($sformatf("v%0d_busy_after", v), busy, 0);
            if (vecs[v].exp_wr == int'(DEPTH)) begin
                seen = '0;
                for (int k = sw; k < wr_idx_q.size(); k++) seen[wr_idx_q[k]] = 1'b1;
                chk("full_depth_coverage", seen, 32'hFFFF_FFFF);
            end
        end

        // Reset after beat 17 of the second row.
        sw = wr_idx_q.size();
        sd = done_cyc_q.size();
        g = 0;
        start_load(10, 3, sc);
        feed(int'(BEATS_PER_ROW) + 18, 0, 32'h0005_0000, g);
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        rst = 1'b0;
        repeat (40) tick();
        chk("midrst_writes", wr_idx_q.size() - sw, 1);
        check_rows(sw, 1, 10, 32'h0005_0000);
        chk("midrst_done_pulses", done_cyc_q.size() - sd, 0);
        chk("midrst_busy", busy, 0);

        // Start pulse with a different base while filling must be ignored.
        sw = wr_idx_q.size();
        sd = done_cyc_q.size();
        g = 0;
        start_load(0, 2, sc);
        feed(10, 0, 32'h0006_0000, g);
        chk("busy_during_fill", busy, 1);
        start = 1'b1;
        base_idx = IDX_W'(20);
        num_rows = (IDX_W+1)'(5);
        tick();
        start = 1'b0;
        feed(2 * int'(BEATS_PER_ROW) - 10, 0, 32'h0006_0000, g);
        wait_done(sd);
        chk("busystart_writes", wr_idx_q.size() - sw, 2);
        check_rows(sw, 2, 0, 32'h0006_0000);
        chk("busystart_done_pulses", done_cyc_q.size() - sd, 1);
        chk("busystart_busy_after", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
